// File: rtl/seq_multiplier_n.sv
// Shift-add sequential multiplier: WIDTH iterations after Start, product on {X, Aval, Bval}.
// Define MULT_SIGNED_EN to add the Signed_Mode port and two's-complement datapath.
module seq_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
`ifdef MULT_SIGNED_EN
  input  logic             Signed_Mode,
`endif
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic             fill;

`ifdef MULT_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             sub;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   addend;

  // Final iteration subtracts the multiplicand when the multiplier sign bit is set.
  always_comb begin
    m_ext  = {sgn_q & m_q[WIDTH-1], m_q};
    sub    = sgn_q & (cnt_q == LAST) & b_q[0];
    addend = '0;
    if (b_q[0]) begin
      addend = sub ? ~m_ext : m_ext;
    end
    sum  = {sgn_q & a_q[WIDTH-1], a_q} + addend + {{WIDTH{1'b0}}, sub};
    fill = sgn_q & sum[WIDTH];
  end
`else
  always_comb begin
    sum  = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    fill = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
`ifdef MULT_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = '0;
          b_d     = Multiplier;
          m_d     = Multiplicand;
          x_d     = 1'b0;
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          sgn_d   = Signed_Mode;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        {x_d, a_d, b_d} = {fill, sum, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!Start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
`ifdef MULT_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Bench for seq_multiplier_n (WIDTH=8): arithmetic product model checked every cycle,
// plus directed vectors with literal expected products and timing.
module tb_seq_multiplier_n;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic         Signed_Mode;
  logic [W-1:0] Multiplicand;
  logic [W-1:0] Multiplier;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Aval;
  logic [W-1:0] Bval;
  logic         X;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  seq_multiplier_n #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
`ifdef MULT_SIGNED_EN
    .Signed_Mode  (Signed_Mode),
`endif
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Busy         (Busy),
    .Done         (Done),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact product as a (2W+1)-bit value {X, Aval, Bval}.
  function automatic logic [2*W:0] expected_xab(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[2*W:0];
  endfunction

  function automatic logic eff_sign(input logic s);
`ifdef MULT_SIGNED_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  // Model: phase of the operation, cycles left, result visible outside RUN.
  typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;
  phase_t       ph = P_IDLE;
  int           left = 0;
  logic [2*W:0] pend = '0;
  logic [2*W:0] xab  = '0;

  always @(posedge Clk) begin
    if (Reset) begin
      ph  = P_IDLE;
      xab = '0;
    end else begin
      case (ph)
        P_IDLE: if (Start) begin
          pend = expected_xab(Multiplicand, Multiplier, eff_sign(Signed_Mode));
          left = W;
          ph   = P_RUN;
        end
        P_RUN: begin
          left--;
          if (left == 0) begin
            ph  = P_DONE;
            xab = pend;
          end
        end
        P_DONE: if (!Start) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy_vs_model", 64'(Busy), 64'(ph == P_RUN));
      check("done_vs_model", 64'(Done), 64'(ph == P_DONE));
      if (ph != P_RUN) check("product_vs_model", 64'({X, Aval, Bval}), 64'(xab));
    end
  end

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W:0] exp, input string name);
    int cyc;
    int busy_cnt;
    @(posedge Clk); #1;
    Multiplicand = a;
    Multiplier   = b;
    Signed_Mode  = s;
    Start        = 1'b1;
    @(posedge Clk); #1;
    // Accepted; scramble inputs so only latched values can matter.
    Start        = 1'b0;
    Multiplicand = ~a;
    Multiplier   = b ^ 8'h5A;
    Signed_Mode  = ~s;
    cyc = 0;
    busy_cnt = 0;
    while (!Done && cyc < 40) begin
      busy_cnt += int'(Busy);
      @(posedge Clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(W));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({name, "_product"}, 64'({X, Aval, Bval}), 64'(exp));
    check({name, "_model_pin"}, 64'(xab), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [2*W:0] held;
    Reset = 1'b1;
    Start = 1'b0;
    Signed_Mode = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_product", 64'({X, Aval, Bval}), 64'd0);

    do_mult(8'hFF, 8'hFF, 1'b0, 17'h0FE01, "u_ff_ff");
    do_mult(8'h00, 8'hA5, 1'b0, 17'h00000, "u_zero_m");
    do_mult(8'h5A, 8'h00, 1'b0, 17'h00000, "u_zero_mult");
    do_mult(8'h0D, 8'h0B, 1'b0, 17'h0008F, "u_0d_0b");
    do_mult(8'h80, 8'h02, 1'b0, 17'h00100, "u_80_02");
    do_mult(8'h01, 8'hFF, 1'b0, 17'h000FF, "u_01_ff");
`ifdef MULT_SIGNED_EN
    do_mult(8'hF9, 8'h03, 1'b1, 17'h1FFEB, "s_f9_03");
    do_mult(8'h80, 8'h80, 1'b1, 17'h04000, "s_80_80");
    do_mult(8'hFF, 8'hFF, 1'b1, 17'h00001, "s_ff_ff");
    do_mult(8'h7F, 8'h80, 1'b1, 17'h1C080, "s_7f_80");
`endif

    // Reset in the fourth RUN cycle, with Start still high.
    @(posedge Clk); #1;
    Multiplicand = 8'h37;
    Multiplier   = 8'h5B;
    Signed_Mode  = 1'b0;
    Start        = 1'b1;
    @(posedge Clk); #1;
    repeat (3) @(posedge Clk);
    #1;
    check("abort_busy_before", 64'(Busy), 64'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    Start = 1'b0;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_product", 64'({X, Aval, Bval}), 64'd0);

    // Start held high through RUN and DONE.
    @(posedge Clk); #1;
    Multiplicand = 8'hC3;
    Multiplier   = 8'h2E;
    Start        = 1'b1;
    cyc = 0;
    @(posedge Clk); #1;
    while (!Done && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check("hold_latency", 64'(cyc), 64'(W));
    held = {X, Aval, Bval};
    check("hold_product", 64'(held), 64'h0230A);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check("hold_done_stays", 64'(Done), 64'd1);
      check("hold_product_stable", 64'({X, Aval, Bval}), 64'h0230A);
    end
    Start = 1'b0;
    @(posedge Clk); #1;
    check("release_done", 64'(Done), 64'd0);
    check("release_busy", 64'(Busy), 64'd0);
    check("idle_holds_product", 64'({X, Aval, Bval}), 64'h0230A);
    repeat (3) @(posedge Clk);
    #1;
    check("idle_still_holds", 64'({X, Aval, Bval}), 64'h0230A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
